dm_access_ctrl: RTL and testbench
=================================

Name: dm_access_ctrl

Overview:
Sequences every data-memory access issued by the MEM pipeline stage against a variable-latency data memory with a ready handshake. Decodes the load/store opcode and computes byte lanes. Replicates store data and extends load data. Detects misaligned addresses and bus timeouts, and holds the pipeline stall until the access retires.

Parameters:
TIMEOUT, 16, max cycles waiting for mem_ready before bus error; 0 disables the timeout.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  MEM stage holds a valid instruction
ins  in  32  instruction in MEM stage; opcode is ins[31:26]
addr  in  32  effective address
wdata  in  32  store source register value
stall  out  1  freeze the pipeline upstream of MEM
done  out  1  one-cycle pulse: access retired, rdata/flags valid
rdata  out  32  extended load result, valid while done=1
exc_adel  out  1  misaligned load, valid while done=1
exc_ades  out  1  misaligned store, valid while done=1
bus_err  out  1  timeout on memory, valid while done=1
mem_req  out  1  access request to memory
mem_we  out  1  1 = write
mem_be  out  4  byte enables, lane 0 = bits 7:0
mem_addr  out  32  word-aligned address, addr with bits 1:0 cleared
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  memory read word
mem_ready  in  1  memory completes the access this cycle

Behaviour:
- Opcodes:
  - Loads: lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100.
  - Stores: sw 101011, sh 101001, sb 101000, swe 011111 (swe is a word store).
  - Any other opcode is a non-memory op.
- States: IDLE, ISSUE, DONE. Reset sets state=IDLE and every registered output to 0, including rdata, flags, mem_* and counter.
- IDLE:
  - req_valid with a memory op and aligned address: latch op, addr and wdata; go to ISSUE.
  - req_valid with a memory op and misaligned address: go to DONE with exc_adel (load) or exc_ades (store); no mem_req is issued.
  - Non-memory op or req_valid=0: stay in IDLE, no effect.
- Alignment rules: word ops require addr[1:0]=00; half ops require addr[0]=0; byte ops are always aligned.
- ISSUE:
  - mem_req=1, and mem_we/mem_be/mem_addr/mem_wdata are stable from registers.
  - mem_ready=1: capture mem_rdata, go to DONE.
  - Cycle counter increments each ISSUE cycle. When TIMEOUT≠0 and the counter reaches TIMEOUT-1 without ready: go to DONE with bus_err=1 and rdata=0.
- DONE: done=1 for exactly one cycle, then return to IDLE. The next request may be accepted in the following IDLE cycle.
- stall (combinational):
  - 1 in IDLE when req_valid and the op is a memory op.
  - 1 throughout ISSUE.
  - 0 in DONE, so the stage advances on the edge that ends DONE.
- Minimum aligned-access latency with mem_ready in the first ISSUE cycle: request edge → ISSUE (1 cycle) → DONE (1 cycle), i.e. 2 stall cycles.
- Byte enables:
  - word: 1111
  - half: addr[1] ? 1100 : 0011
  - byte: one-hot of addr[1:0] (00→0001, 01→0010, 10→0100, 11→1000)
  - loads use the same enables with mem_we=0.
- Store data: sb replicates wdata[7:0] into all four lanes; sh replicates wdata[15:0] into both halves; word stores pass wdata unchanged.
- Load extension (lane selected by latched addr):
  - lb sign-extends the byte; lbu zero-extends it.
  - lh/lhu select the half by addr[1], sign- or zero-extended respectively.
  - lw passes the word unchanged.
- mem_ready in IDLE or DONE is ignored.
- Synchronous reset mid-ISSUE: the FSM aborts to IDLE at that edge; mem_req=0 from the following cycle; no done pulse is issued for the aborted access.
- ins/addr/wdata changes during ISSUE are ignored (latched copy used).

Decomposition:
- Shared package holds:
  - opcode constants
  - FSM state encoding (IDLE/ISSUE/DONE, 2 bits)
  - lane-size encoding (BYTE/HALF/WORD)
- One combinational sub-module, mem_lane_decode. Inputs: size, signedness, addr[1:0]. Outputs: byte enables, replicated store data, extended load data, misalignment flag.
- The FSM, timeout counter and latches stay in dm_access_ctrl.

Test Plan:
- sb, addr=0x0000_0013, wdata=0x0000_00A5, mem_ready on the first ISSUE cycle → mem_be=1000, mem_addr=0x10, mem_wdata=0xA5A5_A5A5, mem_we=1; stall high 2 cycles; done 1 cycle later.
- lb at addr 0x22 returning mem_rdata=0x0080_0000 → rdata=0xFFFF_FF80. Same with lbu → 0x0000_0080. lh at 0x22 with mem_rdata=0x8001_0000 → 0xFFFF_8001.
- lw at addr 0x0000_0006 → exc_adel=1 with done; mem_req never asserted. sh at 0x05 → exc_ades=1.
- sw with mem_ready held low, TIMEOUT=16 → mem_req high 16 cycles, then done with bus_err=1, rdata=0; FSM back in IDLE.
- lw with mem_ready after 3 wait cycles, reset pulsed in the 2nd ISSUE cycle → IDLE, mem_req=0 next cycle, no done; a later sw completes normally with mem_be=1111.
- Non-memory opcode (000000) with req_valid=1 → stall=0, mem_req=0, no done. swe (011111) → behaves as sw, mem_be=1111.

Source files
------------

// File: rtl/dm_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: opcodes,
// FSM state encoding, lane sizes and the opcode decoder.
package dm_access_ctrl_pkg;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SWE = 6'b011111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } lane_size_e;

  typedef struct packed {
    logic       is_mem;
    logic       is_store;
    lane_size_e size;
    logic       sign;
  } mem_op_t;

  function automatic mem_op_t decode_op(input logic [5:0] opc);
    mem_op_t op;
    op.is_mem   = 1'b1;
    op.is_store = 1'b0;
    op.size     = SZ_WORD;
    op.sign     = 1'b0;
    case (opc)
      OP_LW:  op.size = SZ_WORD;
      OP_LH:  begin op.size = SZ_HALF; op.sign = 1'b1; end
      OP_LHU: op.size = SZ_HALF;
      OP_LB:  begin op.size = SZ_BYTE; op.sign = 1'b1; end
      OP_LBU: op.size = SZ_BYTE;
      OP_SW, OP_SWE: op.is_store = 1'b1;
      OP_SH:  begin op.is_store = 1'b1; op.size = SZ_HALF; end
      OP_SB:  begin op.is_store = 1'b1; op.size = SZ_BYTE; end
      default: op.is_mem = 1'b0;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/dm_access_ctrl_if.sv
// Data-memory bus between the access controller (master) and the memory (slave).
interface dm_access_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/dm_access_ctrl_mem_lane_decode.sv
// Byte-lane logic: enables, store replication, load extension and
// alignment check for a given access size and low address bits.
module mem_lane_decode
  import dm_access_ctrl_pkg::*;
(
  input  lane_size_e  size,
  input  logic        sign,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_raw[7:0];
    case (lane)
      2'd1:    byte_sel = rdata_raw[15:8];
      2'd2:    byte_sel = rdata_raw[23:16];
      2'd3:    byte_sel = rdata_raw[31:24];
      default: byte_sel = rdata_raw[7:0];
    endcase
  end

  assign half_sel = lane[1] ? rdata_raw[31:16] : rdata_raw[15:0];

  always_comb begin
    be         = 4'b1111;
    wdata_rep  = wdata;
    rdata_ext  = rdata_raw;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{sign & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        be         = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{wdata[15:0]}};
        rdata_ext  = {{16{sign & half_sel[15]}}, half_sel};
        misaligned = lane[0];
      end
      default: misaligned = |lane;
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// Sequences MEM-stage loads/stores against a variable-latency data memory.
//   state    | meaning
//   ST_IDLE  | waiting for a memory op; accepts or flags misalignment
//   ST_ISSUE | mem_req held until mem_ready or timeout
//   ST_DONE  | one-cycle done pulse with rdata/flags
module dm_access_ctrl
  import dm_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [31:0]      ins,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic             stall,
  output logic             done,
  output logic [31:0]      rdata,
  output logic             exc_adel,
  output logic             exc_ades,
  output logic             bus_err,
  dm_access_ctrl_if.master mem
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e      state;
  mem_op_t     cur_op;
  logic        lat_store;
  logic        lat_sign;
  lane_size_e  lat_size;
  logic [1:0]  lat_lane;
  logic [CW-1:0] cnt;

  lane_size_e  dec_size;
  logic        dec_sign;
  logic [1:0]  dec_lane;
  logic [3:0]  dec_be;
  logic [31:0] dec_wdata;
  logic [31:0] dec_rdata;
  logic        dec_mis;
  logic        timeout_hit;
  logic        unused_ins;

  assign cur_op     = decode_op(ins[31:26]);
  assign unused_ins = ^ins[25:0];

  // Live request drives the lane decoder in IDLE; the latched copy afterwards.
  assign dec_size = (state == ST_IDLE) ? cur_op.size : lat_size;
  assign dec_sign = (state == ST_IDLE) ? cur_op.sign : lat_sign;
  assign dec_lane = (state == ST_IDLE) ? addr[1:0]   : lat_lane;

  mem_lane_decode u_lane (
    .size       (dec_size),
    .sign       (dec_sign),
    .lane       (dec_lane),
    .wdata      (wdata),
    .rdata_raw  (mem.mem_rdata),
    .be         (dec_be),
    .wdata_rep  (dec_wdata),
    .rdata_ext  (dec_rdata),
    .misaligned (dec_mis)
  );

  assign timeout_hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
  assign stall = ((state == ST_IDLE) && req_valid && cur_op.is_mem) || (state == ST_ISSUE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      lat_store     <= 1'b0;
      lat_sign      <= 1'b0;
      lat_size      <= SZ_BYTE;
      lat_lane      <= 2'b00;
      cnt           <= '0;
      done          <= 1'b0;
      rdata         <= '0;
      exc_adel      <= 1'b0;
      exc_ades      <= 1'b0;
      bus_err       <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_be    <= 4'b0000;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else begin
      done     <= 1'b0;
      exc_adel <= 1'b0;
      exc_ades <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid && cur_op.is_mem) begin
            if (dec_mis) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              rdata    <= '0;
              exc_adel <= ~cur_op.is_store;
              exc_ades <= cur_op.is_store;
            end else begin
              state         <= ST_ISSUE;
              lat_store     <= cur_op.is_store;
              lat_sign      <= cur_op.sign;
              lat_size      <= cur_op.size;
              lat_lane      <= addr[1:0];
              cnt           <= '0;
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= cur_op.is_store;
              mem.mem_be    <= dec_be;
              mem.mem_addr  <= {addr[31:2], 2'b00};
              mem.mem_wdata <= dec_wdata;
            end
          end
        end
        ST_ISSUE: begin
          if (mem.mem_ready) begin
            state       <= ST_DONE;
            done        <= 1'b1;
            rdata       <= lat_store ? 32'h0 : dec_rdata;
            mem.mem_req <= 1'b0;
          end else if (timeout_hit) begin
            state       <= ST_DONE;
            done        <= 1'b1;
            rdata       <= '0;
            bus_err     <= 1'b1;
            mem.mem_req <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl with a transaction-level expectation model.
module tb_dm_access_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] ins = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        stall, done, exc_adel, exc_ades, bus_err;
  logic [31:0] rdata;

  dm_access_ctrl_if mem_bus();

  dm_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .ins       (ins),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .done      (done),
    .rdata     (rdata),
    .exc_adel  (exc_adel),
    .exc_ades  (exc_ades),
    .bus_err   (bus_err),
    .mem       (mem_bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        chk_en = 1'b0;
  logic        exp_stall = 1'b0, exp_req = 1'b0, exp_done = 1'b0, exp_we = 1'b0;
  logic        exp_adel = 1'b0, exp_ades = 1'b0, exp_berr = 1'b0, exp_chk_rdata = 1'b0;
  logic [3:0]  exp_be = '0;
  logic [31:0] exp_maddr = '0, exp_wdata = '0, exp_rdata = '0;

  typedef struct {
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] rdata;
    logic        adel;
    logic        ades;
    logic        berr;
    int          req_n;
    int          stall_n;
    int          done_n;
  } cap_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  // Opcode table: membership, direction, access size in bytes, signedness.
  function automatic void classify(input logic [5:0] opc, output bit m, output bit st,
                                   output int sz, output bit sg);
    m = 1; st = 0; sz = 4; sg = 0;
    case (opc)
      6'b100011: sz = 4;
      6'b100001: begin sz = 2; sg = 1; end
      6'b100101: sz = 2;
      6'b100000: begin sz = 1; sg = 1; end
      6'b100100: sz = 1;
      6'b101011, 6'b011111: st = 1;
      6'b101001: begin st = 1; sz = 2; end
      6'b101000: begin st = 1; sz = 1; end
      default: m = 0;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input int sz, input logic [31:0] a);
    if (sz == 4) return 4'hF;
    if (sz == 2) return a[1] ? 4'hC : 4'h3;
    return 4'(1 << a[1:0]);
  endfunction

  function automatic logic [31:0] model_wdata(input int sz, input logic [31:0] wd);
    if (sz == 1) return {4{wd[7:0]}};
    if (sz == 2) return {2{wd[15:0]}};
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input int sz, input bit sg, input logic [31:0] a,
                                             input logic [31:0] mrd);
    logic [31:0] v;
    if (sz == 4) return mrd;
    if (sz == 2) begin
      v = (mrd >> (a[1] ? 16 : 0)) & 32'h0000_FFFF;
      if (sg && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = (mrd >> (8 * a[1:0])) & 32'h0000_00FF;
      if (sg && v[7]) v = v | 32'hFFFF_FF00;
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", stall, exp_stall);
      chk("mem_req", mem_bus.mem_req, exp_req);
      chk("done", done, exp_done);
      if (exp_req) begin
        chk("mem_we", mem_bus.mem_we, exp_we);
        chk("mem_be", mem_bus.mem_be, exp_be);
        chk("mem_addr", mem_bus.mem_addr, exp_maddr);
        if (exp_we) chk("mem_wdata", mem_bus.mem_wdata, exp_wdata);
      end
      if (exp_done) begin
        chk("exc_adel", exc_adel, exp_adel);
        chk("exc_ades", exc_ades, exp_ades);
        chk("bus_err", bus_err, exp_berr);
        if (exp_chk_rdata) chk("rdata", rdata, exp_rdata);
      end
    end
  end

  // One access: w = ISSUE cycle index on which mem_ready rises (-1 = never),
  // rst_at = timeline cycle in which reset is held high (-1 = none).
  task automatic access(input logic [5:0] opc, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] mrd, input int w, input int rst_at, output cap_t c);
    bit m, st, sg, mis, berr, aborted;
    int sz, n, total;
    classify(opc, m, st, sz, sg);
    mis   = m && ((sz == 4 && a[1:0] != 2'b00) || (sz == 2 && a[0]));
    berr  = m && !mis && (TIMEOUT != 0) && (w < 0 || w >= TIMEOUT);
    n     = (!m || mis) ? 0 : (berr ? TIMEOUT : w + 1);
    total = (!m || mis) ? 2 : n + 2;
    c = '{default: '0};
    exp_we        = st;
    exp_be        = model_be(sz, a);
    exp_maddr     = {a[31:2], 2'b00};
    exp_wdata     = model_wdata(sz, wd);
    exp_adel      = mis && !st;
    exp_ades      = mis && st;
    exp_berr      = berr;
    exp_chk_rdata = !mis && ((m && !st) || berr);
    exp_rdata     = berr ? 32'h0 : model_load(sz, sg, a, mrd);
    aborted = 0;
    for (int k = 0; k < total; k++) begin
      @(posedge clk); #1;
      mem_bus.mem_ready = 1'b0;
      mem_bus.mem_rdata = 32'hDEAD_BEEF;
      if (aborted || (rst_at > 0 && k == rst_at + 1)) begin
        aborted   = 1;
        reset     = 1'b0;
        req_valid = 1'b0;
        exp_stall = 1'b0;
        exp_req   = 1'b0;
        exp_done  = 1'b0;
      end else begin
        req_valid = 1'b1;
        if (k >= 1 && k <= n) begin
          ins   = {6'b000000, 26'h155_5555};
          addr  = ~a;
          wdata = ~wd;
        end else begin
          ins   = {opc, 26'h00A_BCDE};
          addr  = a;
          wdata = wd;
        end
        reset     = (k == rst_at);
        exp_stall = (m && k == 0) || (k >= 1 && k <= n);
        exp_req   = (k >= 1 && k <= n);
        exp_done  = m && (k == total - 1);
      end
      if (k >= 1 && k - 1 == w) begin
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rdata = mrd;
      end
      @(negedge clk);
      if (stall) c.stall_n++;
      if (mem_bus.mem_req) begin
        if (c.req_n == 0) begin
          c.be     = mem_bus.mem_be;
          c.maddr  = mem_bus.mem_addr;
          c.mwdata = mem_bus.mem_wdata;
        end
        c.req_n++;
      end
      if (done) begin
        c.done_n++;
        c.rdata = rdata;
        c.adel  = exc_adel;
        c.ades  = exc_ades;
        c.berr  = bus_err;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset     = 1'b0;
    ins       = '0;
    mem_bus.mem_ready = 1'b0;
    exp_stall = 1'b0;
    exp_req   = 1'b0;
    exp_done  = 1'b0;
  endtask

  typedef struct {
    logic [5:0]  opc;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] mrd;
    int          w;
  } vec_t;

  vec_t vecs[6] = '{
    '{6'b100101, 32'h0000_0102, 32'h0,         32'h8001_7FFF, 0},
    '{6'b100011, 32'h0000_0040, 32'h0,         32'h1234_5678, 2},
    '{6'b101001, 32'h0000_0006, 32'h1234_BEEF, 32'h0,         1},
    '{6'b100000, 32'h0000_0031, 32'h0,         32'h0000_7F00, 0},
    '{6'b101000, 32'h0000_0020, 32'h0000_3C11, 32'h0,         4},
    '{6'b100001, 32'h0000_0054, 32'h0,         32'h0000_9ABC, 0}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    cap_t c;
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rdata = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_adel", exc_adel, 0);
    chk("rst_ades", exc_ades, 0);
    chk("rst_berr", bus_err, 0);
    chk("rst_req", mem_bus.mem_req, 0);
    chk("rst_we", mem_bus.mem_we, 0);
    chk("rst_be", mem_bus.mem_be, 0);
    chk("rst_addr", mem_bus.mem_addr, 0);
    chk("rst_wdata", mem_bus.mem_wdata, 0);
    @(posedge clk); #1;
    reset  = 1'b0;
    chk_en = 1'b1;

    access(6'b101000, 32'h0000_0013, 32'h0000_00A5, 32'h0, 0, -1, c);
    chk("sb_be", c.be, 4'b1000);
    chk("sb_addr", c.maddr, 32'h0000_0010);
    chk("sb_wdata", c.mwdata, 32'hA5A5_A5A5);
    chk("sb_stall_n", c.stall_n, 2);
    chk("sb_done_n", c.done_n, 1);

    access(6'b100000, 32'h0000_0022, 32'h0, 32'h0080_0000, 0, -1, c);
    chk("lb_rdata", c.rdata, 32'hFFFF_FF80);
    access(6'b100100, 32'h0000_0022, 32'h0, 32'h0080_0000, 0, -1, c);
    chk("lbu_rdata", c.rdata, 32'h0000_0080);
    access(6'b100001, 32'h0000_0022, 32'h0, 32'h8001_0000, 0, -1, c);
    chk("lh_rdata", c.rdata, 32'hFFFF_8001);

    access(6'b100011, 32'h0000_0006, 32'h0, 32'h0, 0, -1, c);
    chk("lw_mis_adel", c.adel, 1);
    chk("lw_mis_req_n", c.req_n, 0);
    chk("lw_mis_done_n", c.done_n, 1);
    access(6'b101001, 32'h0000_0005, 32'h1111_2222, 32'h0, 0, -1, c);
    chk("sh_mis_ades", c.ades, 1);
    chk("sh_mis_req_n", c.req_n, 0);

    access(6'b101011, 32'h0000_0080, 32'hCAFE_F00D, 32'h0, -1, -1, c);
    chk("to_req_n", c.req_n, 16);
    chk("to_berr", c.berr, 1);
    chk("to_rdata", c.rdata, 32'h0);

    access(6'b100011, 32'h0000_0100, 32'h0, 32'h5555_AAAA, 3, 2, c);
    chk("abort_done_n", c.done_n, 0);
    chk("abort_req_n", c.req_n, 2);
    access(6'b101011, 32'h0000_0104, 32'h0BAD_C0DE, 32'h0, 1, -1, c);
    chk("post_sw_be", c.be, 4'b1111);
    chk("post_sw_done_n", c.done_n, 1);

    access(6'b000000, 32'h0000_0010, 32'h0, 32'h0, 0, -1, c);
    chk("nop_stall_n", c.stall_n, 0);
    chk("nop_req_n", c.req_n, 0);
    chk("nop_done_n", c.done_n, 0);
    access(6'b011111, 32'h0000_0200, 32'h1357_9BDF, 32'h0, 0, -1, c);
    chk("swe_be", c.be, 4'b1111);
    chk("swe_req_n", c.req_n, 1);
    chk("swe_wdata", c.mwdata, 32'h1357_9BDF);

    for (int i = 0; i < 6; i++) begin
      access(vecs[i].opc, vecs[i].a, vecs[i].wd, vecs[i].mrd, vecs[i].w, -1, c);
    end
    access(6'b100101, 32'h0000_0102, 32'h0, 32'h8001_7FFF, 0, -1, c);
    chk("lhu_hi_rdata", c.rdata, 32'h0000_8001);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
